// File: rtl/corefifo_sync_rst_seq_if.sv
// ---------------------------------------------------------------------------
// corefifo_sync_rst_seq_if
// Purpose : Groups the control-side and chain-side signals of the FIFO
//           reset/flush sequencer into one bundle.
// Signals :
//   flush_req   control -> seq   4-phase flush request (level)
//   flush_ack   seq -> control   flush complete, held until flush_req falls
//   sync_ptr    chain -> seq     synchronized pointer, ADDRWIDTH+1 bits
//   err_clr     control -> seq   clears the sticky timeout flag
//   srstn       seq -> chain     synchronous reset, active-low
//   busy        seq -> control   sequence in progress
//   ready       seq -> control   chain settled, FIFO usable
//   wr_allow    seq -> FIFO      write-enable gate
//   rd_allow    seq -> FIFO      read-enable gate
//   err_timeout seq -> control   sticky settle-timeout flag
// Modports : master = control/chain side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface corefifo_sync_rst_seq_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 flush_req;
    logic                 flush_ack;
    logic [ADDRWIDTH:0]   sync_ptr;
    logic                 err_clr;
    logic                 srstn;
    logic                 busy;
    logic                 ready;
    logic                 wr_allow;
    logic                 rd_allow;
    logic                 err_timeout;

    modport master (
        output flush_req, sync_ptr, err_clr,
        input  flush_ack, srstn, busy, ready, wr_allow, rd_allow, err_timeout
    );

    modport slave (
        input  flush_req, sync_ptr, err_clr,
        output flush_ack, srstn, busy, ready, wr_allow, rd_allow, err_timeout
    );
endinterface

// File: rtl/corefifo_sync_rst_seq.sv
// ---------------------------------------------------------------------------
// corefifo_sync_rst_seq
// Purpose : Reset/flush sequencer for a FIFO pointer synchronizer chain.
//           Holds the chain in synchronous reset for RST_CYCLES, then waits
//           until the synchronized pointer reads zero for NUM_STAGES+1
//           consecutive cycles before declaring the FIFO ready. Serves
//           4-phase flush requests and flags settle timeouts (sticky).
// Ports   :
//   clk   in   single clock, posedge
//   arst  in   asynchronous reset, active-high
//   bus   slave modport of corefifo_sync_rst_seq_if (see interface header)
// All outputs are decoded from the registered state only (Moore).
// ---------------------------------------------------------------------------
module corefifo_sync_rst_seq #(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int RST_CYCLES = 4,
    parameter int SETTLE_MAX = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      arst,
    corefifo_sync_rst_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(NUM_STAGES);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST    = CNT_WIDTH'(SETTLE_MAX - 1);

    state_t               state_q,      state_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q,   hold_cnt_d;
    logic [CNT_WIDTH-1:0] stable_cnt_q, stable_cnt_d;
    logic [CNT_WIDTH-1:0] tmo_cnt_q,    tmo_cnt_d;
    logic                 from_flush_q, from_flush_d;
    logic                 err_q,        err_d;

    logic ptr_zero;
    assign ptr_zero = (bus.sync_ptr == '0);

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            from_flush_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            from_flush_q <= from_flush_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stable_cnt_d = stable_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        from_flush_d = from_flush_q;
        // Clear first so that a timeout later in this block overrides it.
        err_d        = bus.err_clr ? 1'b0 : err_q;

        case (state_q)
            ST_HOLD: begin
                stable_cnt_d = '0;
                tmo_cnt_d    = '0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_SETTLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end

            ST_SETTLE: begin
                tmo_cnt_d    = sat_inc(tmo_cnt_q);
                stable_cnt_d = ptr_zero ? sat_inc(stable_cnt_q) : '0;
                // Exit is checked before timeout so it wins a same-cycle tie.
                if (ptr_zero && (stable_cnt_q == STABLE_LAST)) begin
                    state_d      = from_flush_q ? ST_ACK : ST_READY;
                    stable_cnt_d = '0;
                    tmo_cnt_d    = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Retry the whole sequence; a pending flush stays pending.
                    state_d      = ST_HOLD;
                    err_d        = 1'b1;
                    stable_cnt_d = '0;
                    tmo_cnt_d    = '0;
                end
            end

            ST_READY: begin
                if (bus.flush_req) begin
                    state_d      = ST_HOLD;
                    from_flush_d = 1'b1;
                    hold_cnt_d   = '0;
                end
            end

            ST_ACK: begin
                if (!bus.flush_req) begin
                    state_d      = ST_READY;
                    from_flush_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Moore decode: allows fall on the same edge that srstn falls.
    always_comb begin
        bus.srstn       = (state_q != ST_HOLD);
        bus.busy        = (state_q == ST_HOLD) || (state_q == ST_SETTLE);
        bus.ready       = (state_q == ST_READY) || (state_q == ST_ACK);
        bus.wr_allow    = (state_q == ST_READY) || (state_q == ST_ACK);
        bus.rd_allow    = (state_q == ST_READY) || (state_q == ST_ACK);
        bus.flush_ack   = (state_q == ST_ACK);
        bus.err_timeout = err_q;
    end

endmodule

// File: tb/tb_corefifo_sync_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_corefifo_sync_rst_seq
// Directed bench for the FIFO reset/flush sequencer. Each step advances one
// clock and compares the packed output vector
//   {srstn, busy, ready, wr_allow, rd_allow, flush_ack, err_timeout}
// against values worked out by hand from the cycle timelines below.
// ---------------------------------------------------------------------------
module tb_corefifo_sync_rst_seq;

    localparam logic [6:0] O_HOLD   = 7'b0100000;
    localparam logic [6:0] O_SETTLE = 7'b1100000;
    localparam logic [6:0] O_READY  = 7'b1011100;
    localparam logic [6:0] O_ACK    = 7'b1011110;

    logic clk;
    logic arst;
    int   n_cmp;
    int   n_err;

    corefifo_sync_rst_seq_if #(.ADDRWIDTH(3)) bus ();

    corefifo_sync_rst_seq #(
        .NUM_STAGES (2),
        .ADDRWIDTH  (3),
        .RST_CYCLES (4),
        .SETTLE_MAX (16),
        .CNT_WIDTH  (8)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int c, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.srstn, bus.busy, bus.ready, bus.wr_allow, bus.rd_allow,
               bus.flush_ack, bus.err_timeout};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s c%0d: observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    initial begin
        logic [6:0] exp;
        n_cmp = 0;
        n_err = 0;
        arst          = 1'b1;
        bus.flush_req = 1'b0;
        bus.sync_ptr  = '0;
        bus.err_clr   = 1'b0;

        // Reset state
        repeat (3) step();
        check("reset", 0, O_HOLD);
        $display("reset: outputs held in reset state");

        // 1: power-up with a clean pointer, READY at c7
        arst = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            exp = (c < 4) ? O_HOLD : (c < 7) ? O_SETTLE : O_READY;
            check("powerup", c, exp);
            if (c < 7) step();
        end
        $display("powerup: READY reached");

        // 2: flush handshake; ack at c8, release at c10, READY at c11
        for (int c = 0; c <= 12; c++) begin
            if (c == 0)  bus.flush_req = 1'b1;
            if (c == 10) bus.flush_req = 1'b0;
            exp = (c == 0) ? O_READY : (c < 5) ? O_HOLD : (c < 8) ? O_SETTLE :
                  (c < 11) ? O_ACK : O_READY;
            check("flush", c, exp);
            if (c < 12) step();
        end
        $display("flush: 4-phase handshake complete");

        // 3: dirty pointer for the first two SETTLE cycles, READY 3 cycles after zero
        arst = 1'b1;
        step();
        arst = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            bus.sync_ptr = (c == 4 || c == 5) ? 4'h5 : 4'h0;
            exp = (c < 4) ? O_HOLD : (c < 9) ? O_SETTLE : O_READY;
            check("dirty", c, exp);
            if (c < 9) step();
        end
        $display("dirty: READY after pointer settled");

        // 4: stuck pointer -> timeout, retry, clear, and set-wins-over-clear
        arst = 1'b1;
        step();
        arst = 1'b0;
        for (int c = 0; c <= 48; c++) begin
            bus.sync_ptr = (c < 40) ? 4'h3 : 4'h0;
            bus.err_clr  = (c == 38 || c == 39 || c == 47);
            exp = (c < 4)  ? O_HOLD : (c < 20) ? O_SETTLE : (c < 24) ? O_HOLD :
                  (c < 40) ? O_SETTLE : (c < 44) ? O_HOLD : (c < 47) ? O_SETTLE : O_READY;
            exp[0] = (c >= 20 && c <= 38) || (c >= 40 && c <= 47);
            check("timeout", c, exp);
            if (c < 48) step();
        end
        bus.err_clr = 1'b0;
        $display("timeout: sticky error set, cleared and re-set");

        // 5: arst during the SETTLE phase of a flush aborts it with no ack
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) bus.flush_req = 1'b1;
            exp = (c == 0) ? O_READY : (c < 5) ? O_HOLD : O_SETTLE;
            check("abort_pre", c, exp);
            if (c < 6) step();
        end
        arst = 1'b1;
        bus.flush_req = 1'b0;
        #1;
        check("abort_async", 6, O_HOLD);
        step();
        arst = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            exp = (c < 4) ? O_HOLD : (c < 7) ? O_SETTLE : O_READY;
            check("abort_post", c, exp);
            if (c < 8) step();
        end
        $display("abort: flush dropped, normal READY");

        // 6: flush_req already high during power-up is served only from READY
        arst = 1'b1;
        step();
        bus.flush_req = 1'b1;
        arst = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            if (c == 16) bus.flush_req = 1'b0;
            exp = (c < 4)  ? O_HOLD : (c < 7)  ? O_SETTLE : (c == 7) ? O_READY :
                  (c < 12) ? O_HOLD : (c < 15) ? O_SETTLE : (c < 17) ? O_ACK : O_READY;
            check("early", c, exp);
            if (c < 17) step();
        end
        $display("early: request deferred until READY, ack at READY+8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
